// File: rtl/tamagotchi_fsm_pkg.sv
// Shared definitions for the virtual-pet controller: need indices,
// indicator codes, 7-segment digit codes and the game state enum.
package tamagotchi_fsm_pkg;

  // Need indices (also the bit position of each need's button pulse)
  localparam int NEED_SALUD     = 0;
  localparam int NEED_ENERGIA   = 1;
  localparam int NEED_HAMBRE    = 2;
  localparam int NEED_DIVERSION = 3;
  localparam int NUM_NEEDS      = 4;

  // Positions of the two control buttons in the pulse vector
  localparam int BTN_RESET = 4;
  localparam int BTN_TEST  = 5;
  localparam int NUM_BTNS  = 6;

  // One-hot selected-need indicator codes
  localparam logic [3:0] DISP_NONE      = 4'b0000;
  localparam logic [3:0] DISP_SALUD     = 4'b0001;
  localparam logic [3:0] DISP_ENERGIA   = 4'b0010;
  localparam logic [3:0] DISP_HAMBRE    = 4'b0100;
  localparam logic [3:0] DISP_DIVERSION = 4'b1000;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_SLEEP    = 2'd1,
    ST_CRITICAL = 2'd2
  } state_t;

  // Digit code for a level; anything above 5 cannot occur and shows blank
  function automatic logic [6:0] seg_code(input logic [2:0] level);
    case (level)
      3'd0:    seg_code = SEG_0;
      3'd1:    seg_code = SEG_1;
      3'd2:    seg_code = SEG_2;
      3'd3:    seg_code = SEG_3;
      3'd4:    seg_code = SEG_4;
      3'd5:    seg_code = SEG_5;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  // One-hot indicator pattern for a need index
  function automatic logic [3:0] need_onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    need_onehot = DISP_SALUD;
      2'd1:    need_onehot = DISP_ENERGIA;
      2'd2:    need_onehot = DISP_HAMBRE;
      2'd3:    need_onehot = DISP_DIVERSION;
      default: need_onehot = DISP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tamagotchi_fsm_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability debounce and a
// single-cycle pulse on the debounced rising edge.
module tamagotchi_fsm_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          meta_r;
  logic          sync_r;
  logic          stable_r;
  logic [CW-1:0] cnt_r;

  // Synchronize, then accept a new level only after it has differed from the
  // accepted level for DEBOUNCE_CYCLES consecutive cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_r   <= 1'b0;
      sync_r   <= 1'b0;
      stable_r <= 1'b0;
      cnt_r    <= '0;
      pulse    <= 1'b0;
    end else begin
      meta_r <= btn;
      sync_r <= meta_r;
      pulse  <= 1'b0;
      if (sync_r != stable_r) begin
        if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable_r <= sync_r;
          cnt_r    <= '0;
          pulse    <= sync_r;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

endmodule

// File: rtl/tamagotchi_fsm.sv
// Virtual-pet game top: button conditioning, game-tick divider, decay timer,
// four saturating need levels, state evaluation and display drivers.
module tamagotchi_fsm
  import tamagotchi_fsm_pkg::*;
#(
  parameter int CLK_FREQ        = 50_000_000,
  parameter int TICK_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int DECAY_TICKS     = 10,
  parameter int TEST_DIV        = 10,
  parameter int MAX_LEVEL       = 5,
  parameter int INIT_LEVEL      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_salud,
  input  logic       btn_energia,
  input  logic       btn_hambre,
  input  logic       btn_diversion,
  input  logic       btn_reset,
  input  logic       btn_test,
  input  logic       ledsign,
  output logic [3:0] display_out,
  output logic [6:0] seg_display,
  output logic       clk_out
);

  localparam int HALF       = CLK_FREQ / (2 * TICK_HZ);
  localparam int DIV_W      = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int TEST_RAW   = DECAY_TICKS / TEST_DIV;
  localparam int TEST_TICKS = (TEST_RAW < 1) ? 1 : TEST_RAW;
  localparam int DEC_W      = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;

  localparam logic [DEC_W-1:0] DEC_LAST_NORM = DEC_W'(DECAY_TICKS - 1);
  localparam logic [DEC_W-1:0] DEC_LAST_TEST = DEC_W'(TEST_TICKS - 1);

  logic [NUM_BTNS-1:0]       press_s;
  logic                      led_meta_r;
  logic                      led_sync_r;
  logic [DIV_W-1:0]          div_cnt_r;
  logic                      tick_s;
  logic [DEC_W-1:0]          dec_cnt_r;
  logic [DEC_W-1:0]          dec_last_s;
  logic                      decay_s;
  logic                      test_mode_r;
  logic                      srst_s;
  logic                      any_zero_s;
  state_t                    cur_state_s;
  state_t                    state_r;
  logic [NUM_NEEDS-1:0][2:0] level_r;
  logic [NUM_NEEDS-1:0][2:0] level_next_s;
  logic [1:0]                sel_r;
  logic [1:0]                sel_next_s;
  logic                      sel_valid_r;
  logic                      sel_valid_next_s;

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    if (v >= 3'(MAX_LEVEL)) begin
      sat_inc = 3'(MAX_LEVEL);
    end else begin
      sat_inc = v + 3'd1;
    end
  endfunction

  function automatic logic [2:0] sat_dec(input logic [2:0] v);
    if (v == 3'd0) begin
      sat_dec = 3'd0;
    end else begin
      sat_dec = v - 3'd1;
    end
  endfunction

  tamagotchi_fsm_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_salud (
    .clk(clk), .reset(reset), .btn(btn_salud), .pulse(press_s[NEED_SALUD]));
  tamagotchi_fsm_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_energia (
    .clk(clk), .reset(reset), .btn(btn_energia), .pulse(press_s[NEED_ENERGIA]));
  tamagotchi_fsm_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_hambre (
    .clk(clk), .reset(reset), .btn(btn_hambre), .pulse(press_s[NEED_HAMBRE]));
  tamagotchi_fsm_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_diversion (
    .clk(clk), .reset(reset), .btn(btn_diversion), .pulse(press_s[NEED_DIVERSION]));
  tamagotchi_fsm_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_reset (
    .clk(clk), .reset(reset), .btn(btn_reset), .pulse(press_s[BTN_RESET]));
  tamagotchi_fsm_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_test (
    .clk(clk), .reset(reset), .btn(btn_test), .pulse(press_s[BTN_TEST]));

  assign srst_s = press_s[BTN_RESET];

  // Light sensor is level-sensitive, only synchronized
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_meta_r <= 1'b0;
      led_sync_r <= 1'b0;
    end else begin
      led_meta_r <= ledsign;
      led_sync_r <= led_meta_r;
    end
  end

  // Game-tick square wave; the game reset button deliberately leaves it running
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_r <= '0;
      clk_out   <= 1'b0;
    end else if (div_cnt_r == DIV_W'(HALF - 1)) begin
      div_cnt_r <= '0;
      clk_out   <= ~clk_out;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // Tick = the cycle clk_out rises; decay fires when the tick counter wraps
  always_comb begin
    tick_s     = (div_cnt_r == DIV_W'(HALF - 1)) && !clk_out;
    dec_last_s = test_mode_r ? DEC_LAST_TEST : DEC_LAST_NORM;
    decay_s    = tick_s && !press_s[BTN_TEST] && (dec_cnt_r >= dec_last_s);
  end

  // State from current levels and light sensor: SLEEP > CRITICAL > NORMAL
  always_comb begin
    any_zero_s = 1'b0;
    for (int i = 0; i < NUM_NEEDS; i++) begin
      if (level_r[i] == 3'd0) begin
        any_zero_s = 1'b1;
      end else begin
        any_zero_s = any_zero_s;
      end
    end
    if (led_sync_r) begin
      cur_state_s = ST_SLEEP;
    end else if (any_zero_s) begin
      cur_state_s = ST_CRITICAL;
    end else begin
      cur_state_s = ST_NORMAL;
    end
  end

  // Next levels and selection; a feed on a need overrides its decay step
  always_comb begin
    level_next_s     = level_r;
    sel_next_s       = sel_r;
    sel_valid_next_s = sel_valid_r;
    for (int i = 0; i < NUM_NEEDS; i++) begin
      if (press_s[i] && sel_valid_r && (sel_r == 2'(i))) begin
        if (cur_state_s != ST_SLEEP) begin
          level_next_s[i] = sat_inc(level_r[i]);
        end else begin
          level_next_s[i] = level_r[i];
        end
      end else if (decay_s) begin
        if (cur_state_s == ST_SLEEP) begin
          if (i == NEED_ENERGIA) begin
            level_next_s[i] = sat_inc(level_r[i]);
          end else begin
            level_next_s[i] = level_r[i];
          end
        end else begin
          level_next_s[i] = sat_dec(level_r[i]);
        end
      end else begin
        level_next_s[i] = level_r[i];
      end
      if (press_s[i] && !(sel_valid_r && (sel_r == 2'(i)))) begin
        sel_next_s       = 2'(i);
        sel_valid_next_s = 1'b1;
      end else begin
        sel_next_s       = sel_next_s;
        sel_valid_next_s = sel_valid_next_s;
      end
    end
  end

  // Game state machine with registered display outputs; btn_reset acts as soft reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_NORMAL;
      level_r     <= {NUM_NEEDS{3'(INIT_LEVEL)}};
      sel_r       <= 2'd0;
      sel_valid_r <= 1'b0;
      test_mode_r <= 1'b0;
      dec_cnt_r   <= '0;
      display_out <= DISP_NONE;
      seg_display <= SEG_BLANK;
    end else if (srst_s) begin
      state_r     <= ST_NORMAL;
      level_r     <= {NUM_NEEDS{3'(INIT_LEVEL)}};
      sel_r       <= 2'd0;
      sel_valid_r <= 1'b0;
      test_mode_r <= 1'b0;
      dec_cnt_r   <= '0;
      display_out <= DISP_NONE;
      seg_display <= SEG_BLANK;
    end else begin
      state_r     <= cur_state_s;
      level_r     <= level_next_s;
      sel_r       <= sel_next_s;
      sel_valid_r <= sel_valid_next_s;
      if (press_s[BTN_TEST]) begin
        test_mode_r <= ~test_mode_r;
        dec_cnt_r   <= '0;
      end else if (tick_s) begin
        test_mode_r <= test_mode_r;
        if (dec_cnt_r >= dec_last_s) begin
          dec_cnt_r <= '0;
        end else begin
          dec_cnt_r <= dec_cnt_r + DEC_W'(1);
        end
      end else begin
        test_mode_r <= test_mode_r;
        dec_cnt_r   <= dec_cnt_r;
      end
      display_out <= sel_valid_r ? need_onehot(sel_r) : DISP_NONE;
      if (!sel_valid_r) begin
        seg_display <= SEG_BLANK;
      end else if ((state_r == ST_CRITICAL) && !clk_out) begin
        seg_display <= SEG_BLANK;
      end else begin
        seg_display <= seg_code(level_r[sel_r]);
      end
    end
  end

endmodule

// File: tb/tb_tamagotchi_fsm.sv
// Self-checking bench for tamagotchi_fsm: directed table, hand-written
// corner sequences and random button traffic against a rule-level model.
module tb_tamagotchi_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_salud, btn_energia, btn_hambre, btn_diversion;
  logic       btn_reset, btn_test, ledsign;
  logic [3:0] display_out;
  logic [6:0] seg_display;
  logic       clk_out;

  always #5 clk = ~clk;

  tamagotchi_fsm #(
    .CLK_FREQ(1000), .TICK_HZ(10), .DEBOUNCE_CYCLES(4), .DECAY_TICKS(4),
    .TEST_DIV(2), .MAX_LEVEL(5), .INIT_LEVEL(3)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_salud(btn_salud), .btn_energia(btn_energia),
    .btn_hambre(btn_hambre), .btn_diversion(btn_diversion),
    .btn_reset(btn_reset), .btn_test(btn_test), .ledsign(ledsign),
    .display_out(display_out), .seg_display(seg_display), .clk_out(clk_out)
  );

  // Model: clk_out half period 50 cycles, tick every 100, decay every 4 ticks (2 in test)
  int lv[4];
  int sel;
  bit tmode;
  int dcnt;
  int cyc;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         btn;
    logic [3:0] disp;
    logic [6:0] seg;
  } vec_t;
  vec_t tbl[4];

  function automatic logic [6:0] digit(input int v);
    case (v)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      default: return 7'b1111111;
    endcase
  endfunction

  // 0 normal, 1 sleep, 2 critical
  function automatic int mstate();
    if (ledsign) return 1;
    for (int i = 0; i < 4; i++) if (lv[i] == 0) return 2;
    return 0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) lv[i] = 3;
    sel = -1; tmode = 1'b0; dcnt = 0;
  endtask

  task automatic m_tick();
    int per;
    per = tmode ? 2 : 4;
    dcnt++;
    if (dcnt >= per) begin
      dcnt = 0;
      if (mstate() == 1) begin
        if (lv[1] < 5) lv[1]++;
      end else begin
        for (int i = 0; i < 4; i++) if (lv[i] > 0) lv[i]--;
      end
    end
  endtask

  task automatic m_press(input int b);
    if (b < 4) begin
      if (sel != b) sel = b;
      else if (mstate() != 1 && lv[b] < 5) lv[b]++;
    end else if (b == 4) begin
      m_reset();
    end else begin
      tmode = ~tmode; dcnt = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (reset) begin
      cyc++;
      if (cyc % 100 == 50) m_tick();
    end
  endtask

  task automatic wait_window();
    step();
    while (cyc % 100 != 55) step();
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_salud = v;
      1: btn_energia = v;
      2: btn_hambre = v;
      3: btn_diversion = v;
      4: btn_reset = v;
      default: btn_test = v;
    endcase
  endtask

  task automatic press(input int b);
    wait_window();
    set_btn(b, 1'b1);
    m_press(b);
    repeat (20) step();
    set_btn(b, 1'b0);
    repeat (10) step();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_model(input string name);
    logic [3:0] ed;
    logic [6:0] es;
    logic       ec;
    ec = 1'((cyc / 50) % 2);
    if (sel < 0) begin
      ed = 4'b0000; es = 7'b1111111;
    end else begin
      ed = 4'(1 << sel);
      if (mstate() == 2 && !ec) es = 7'b1111111;
      else es = digit(lv[sel]);
    end
    check({name, "_disp"}, 32'(display_out), 32'(ed));
    check({name, "_seg"}, 32'(seg_display), 32'(es));
    check({name, "_clk"}, 32'(clk_out), 32'(ec));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{0, 4'b0001, 7'b0110000};
    tbl[1] = '{0, 4'b0001, 7'b0011001};
    tbl[2] = '{0, 4'b0001, 7'b0010010};
    tbl[3] = '{0, 4'b0001, 7'b0010010};

    btn_salud = 0; btn_energia = 0; btn_hambre = 0; btn_diversion = 0;
    btn_reset = 0; btn_test = 0; ledsign = 0;
    reset = 1'b0; cyc = 0;
    m_reset();
    repeat (5) step();
    check("rst_disp", 32'(display_out), 32'h0);
    check("rst_seg", 32'(seg_display), 32'h7f);
    check("rst_clk", 32'(clk_out), 32'h0);
    reset = 1'b1;

    // clk_out half period
    while (cyc < 49) step();
    check("clk_low49", 32'(clk_out), 32'h0);
    step();
    check("clk_high50", 32'(clk_out), 32'h1);

    // Directed salud feeding table (4th entry follows the first decay)
    for (int k = 0; k < 4; k++) begin
      press(tbl[k].btn);
      check($sformatf("tbl%0d_disp", k), 32'(display_out), 32'(tbl[k].disp));
      check($sformatf("tbl%0d_seg", k), 32'(seg_display), 32'(tbl[k].seg));
      check_model($sformatf("tbl%0d_model", k));
    end

    // Glitch shorter than the debounce window is ignored
    wait_window();
    btn_energia = 1'b1;
    repeat (2) step();
    btn_energia = 1'b0;
    repeat (10) step();
    check("glitch_disp", 32'(display_out), 32'b0001);
    check_model("glitch");
    press(1);
    check("energia_sel", 32'(display_out), 32'b0010);
    check_model("energia_sel");

    // Starve everything: critical state, blinking zero
    for (int k = 0; k < 25; k++) wait_window();
    check("crit_digit", 32'(seg_display), 32'(7'b1000000));
    check_model("crit_on");
    while (cyc % 100 != 20) step();
    check("crit_blank", 32'(seg_display), 32'h7f);
    check_model("crit_off");
    press(4);
    check("greset_disp", 32'(display_out), 32'h0);
    check("greset_seg", 32'(seg_display), 32'h7f);
    press(1);
    check("greset_lvl3", 32'(seg_display), 32'(7'b0110000));

    // Sleep: energia recovers to 5, feeding and other levels held
    wait_window();
    ledsign = 1'b1;
    for (int k = 0; k < 8; k++) wait_window();
    repeat (10) step();
    check("sleep_energia5", 32'(seg_display), 32'(7'b0010010));
    check_model("sleep");
    press(1);
    check("sleep_nofeed", 32'(seg_display), 32'(7'b0010010));
    press(0);
    check("sleep_salud3", 32'(seg_display), 32'(7'b0110000));
    check_model("sleep_salud");
    wait_window();
    ledsign = 1'b0;
    repeat (10) step();

    // Test mode: decay every 2 ticks
    press(5);
    for (int k = 0; k < 4; k++) begin
      wait_window();
      repeat (10) step();
      check_model($sformatf("test%0d", k));
    end

    // Random traffic
    for (int it = 0; it < 24; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 4) begin
        press(r);
      end else if (r == 4) begin
        press(5);
      end else if (r == 5) begin
        wait_window();
        ledsign = ~ledsign;
        repeat (10) step();
      end else if (r == 6) begin
        press(4);
      end else begin
        repeat (int'($urandom_range(1, 3))) wait_window();
        repeat (10) step();
      end
      check_model($sformatf("rnd%0d", it));
    end

    // Hardware reset in the middle of a debounce
    wait_window();
    btn_salud = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    #1;
    check("hwrst_disp", 32'(display_out), 32'h0);
    check("hwrst_seg", 32'(seg_display), 32'h7f);
    check("hwrst_clk", 32'(clk_out), 32'h0);
    btn_salud = 1'b0;
    ledsign = 1'b0;
    repeat (3) step();
    cyc = 0;
    m_reset();
    reset = 1'b1;
    wait_window();
    repeat (10) step();
    check_model("after_hwrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
